// File: rtl/regfile_wb_multiport_pkg.sv
// Shared definitions for the multi-port register file with registered write-back.
//   wb_state_t      : write-back controller state (IDLE, WAIT_MEM)
//   ZERO_ADDR       : address of the hard-wired zero register
//   DEF_DATA_W      : default register width
//   DEF_ADDR_W      : default address width (depth = 2**ADDR_W)
//   DEF_LINK_ADDR   : default jal link destination
package regfile_wb_multiport_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } wb_state_t;

  localparam int ZERO_ADDR     = 0;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_ADDR_W    = 5;
  localparam int DEF_LINK_ADDR = 31;

endpackage

// File: rtl/regfile_wb_multiport_rf_read_port.sv
// One read port of the register file: zero-register force, then stage bypass,
// then the array value.
//   rd_addr   : address presented by decode
//   arr_data  : array contents at rd_addr
//   wb_valid  : write-back stage holds a pending write
//   wb_addr   : write-back stage destination
//   wb_data   : write-back stage data
//   rd_data   : resolved read data (combinational)
module rf_read_port
  import regfile_wb_multiport_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] arr_data,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  // The stage register is newer than the array, so it wins on an address hit.
  always_comb begin
    rd_data = arr_data;
    if ((ZERO_REG != 0) && (rd_addr == ZERO_A)) begin
      rd_data = '0;
    end else if (wb_valid && (wb_addr == rd_addr)) begin
      rd_data = wb_data;
    end
  end

endmodule

// File: rtl/regfile_wb_multiport.sv
// Parametrised register file with a registered write-back stage, NUM_RD
// combinational read ports with stage-to-read bypass, and a load handshake.
//   clock, reset : single clock, synchronous active-high reset
//   rd_addr      : packed read addresses, port k at [k*ADDR_W +: ADDR_W]
//   rd_data      : packed read data, port k at [k*DATA_W +: DATA_W]
//   wr_req       : request write-back this cycle
//   wr_jal       : jal link write (dest LINK_ADDR, data opcplus4)
//   wr_dst_sel   : 1 selects wr_rd, 0 selects wr_rt
//   wr_mem       : data from mem_data instead of alu_result
//   wr_rt, wr_rd : destination fields
//   alu_result, mem_data, mem_valid, opcplus4 : write-back sources
//   stall        : waiting for mem_valid; upstream holds its inputs
//   wb_valid, wb_addr, wb_data : write-back stage register contents
module regfile_wb_multiport
  import regfile_wb_multiport_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_RD    = 2,
  parameter int ZERO_REG  = 1,
  parameter int LINK_ADDR = DEF_LINK_ADDR
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_req,
  input  logic                     wr_jal,
  input  logic                     wr_dst_sel,
  input  logic                     wr_mem,
  input  logic [ADDR_W-1:0]        wr_rt,
  input  logic [ADDR_W-1:0]        wr_rd,
  input  logic [DATA_W-1:0]        alu_result,
  input  logic [DATA_W-1:0]        mem_data,
  input  logic                     mem_valid,
  input  logic [DATA_W-1:0]        opcplus4,
  output logic                     stall,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_addr,
  output logic [DATA_W-1:0]        wb_data
);

  localparam int                DEPTH  = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LINK_A = ADDR_W'(LINK_ADDR);
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_ADDR);

  function automatic logic [ADDR_W-1:0] sel_dest(
    input logic              jal,
    input logic              dst_sel,
    input logic [ADDR_W-1:0] rt,
    input logic [ADDR_W-1:0] rd
  );
    if (jal)          return LINK_A;
    else if (dst_sel) return rd;
    else              return rt;
  endfunction

  function automatic logic [DATA_W-1:0] sel_src(
    input logic              jal,
    input logic              mem,
    input logic [DATA_W-1:0] link,
    input logic [DATA_W-1:0] mdata,
    input logic [DATA_W-1:0] alu
  );
    if (jal)      return link;
    else if (mem) return mdata;
    else          return alu;
  endfunction

  logic [DATA_W-1:0] arr [DEPTH];

  wb_state_t         state_p1, state_nx;
  logic [ADDR_W-1:0] pend_addr_p1, pend_addr_nx;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [DATA_W-1:0] data_p1;

  logic              cap_vld;
  logic [ADDR_W-1:0] cap_addr;
  logic [DATA_W-1:0] cap_data;
  logic [ADDR_W-1:0] dest;
  logic [DATA_W-1:0] src;

  assign dest = sel_dest(wr_jal, wr_dst_sel, wr_rt, wr_rd);
  assign src  = sel_src(wr_jal, wr_mem, opcplus4, mem_data, alu_result);

  // jal ignores wr_mem: the link value is always available, so it never waits.
  always_comb begin
    state_nx     = state_p1;
    pend_addr_nx = pend_addr_p1;
    cap_vld      = 1'b0;
    cap_addr     = pend_addr_p1;
    cap_data     = mem_data;
    case (state_p1)
      IDLE: begin
        if (wr_req) begin
          if (wr_jal || !wr_mem || mem_valid) begin
            cap_vld  = 1'b1;
            cap_addr = dest;
            cap_data = src;
          end else begin
            pend_addr_nx = dest;
            state_nx     = WAIT_MEM;
          end
        end
      end
      WAIT_MEM: begin
        if (mem_valid) begin
          cap_vld  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
    // A write aimed at the hard-wired zero register is dropped here so it never
    // reaches the stage (and so never bypasses or commits).
    if ((ZERO_REG != 0) && (cap_addr == ZERO_A)) begin
      cap_vld = 1'b0;
    end
  end

  // Stage p1: controller state, pending load destination, write-back register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_p1     <= IDLE;
      pend_addr_p1 <= '0;
      vld_p1       <= 1'b0;
      addr_p1      <= '0;
      data_p1      <= '0;
    end else begin
      state_p1     <= state_nx;
      pend_addr_p1 <= pend_addr_nx;
      vld_p1       <= cap_vld;
      if (cap_vld) begin
        addr_p1 <= cap_addr;
        data_p1 <= cap_data;
      end
    end
  end

  // Stage p2: commit of the stage register into the array.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        arr[i] <= '0;
      end
    end else if (vld_p1) begin
      arr[addr_p1] <= data_p1;
    end
  end

  assign stall    = (state_p1 == WAIT_MEM);
  assign wb_valid = vld_p1;
  assign wb_addr  = addr_p1;
  assign wb_data  = data_p1;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[k*ADDR_W +: ADDR_W];

    rf_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .rd_addr  (a),
      .arr_data (arr[a]),
      .wb_valid (vld_p1),
      .wb_addr  (addr_p1),
      .wb_data  (data_p1),
      .rd_data  (rd_data[k*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_regfile_wb_multiport.sv
module tb_regfile_wb_multiport;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic            wr_req, wr_jal, wr_dst_sel, wr_mem, mem_valid;
  logic [AW-1:0]   wr_rt, wr_rd;
  logic [DW-1:0]   alu_result, mem_data, opcplus4;
  logic            stall, wb_valid;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;

  int checks   = 0;
  int failures = 0;

  regfile_wb_multiport #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1), .LINK_ADDR(31)
  ) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_req(wr_req), .wr_jal(wr_jal), .wr_dst_sel(wr_dst_sel), .wr_mem(wr_mem),
    .wr_rt(wr_rt), .wr_rd(wr_rd), .alu_result(alu_result), .mem_data(mem_data),
    .mem_valid(mem_valid), .opcplus4(opcplus4), .stall(stall),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 0; wr_jal = 0; wr_dst_sel = 0; wr_mem = 0; mem_valid = 0;
    wr_rt = '0; wr_rd = '0; alu_result = '0; mem_data = '0; opcplus4 = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); rd_addr = {5'd8, 5'd5};
    tick(); tick();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0b exp=0", stall); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
    checks++; if (wb_addr !== 5'd0 || wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb got=%0d/%h exp=0/0", wb_addr, wb_data); end
    reset = 0;
    // enter WAIT_MEM, then reset while waiting
    wr_req = 1; wr_mem = 1; wr_rt = 5'd8; mem_valid = 0;
    tick();
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL wait_entry_stall got=%0b exp=1", stall); end
    reset = 1; wr_req = 0;
    tick();
    reset = 0; wr_mem = 0;
    checks++; if (stall !== 1'b0 || wb_valid !== 1'b0) begin failures++; $display("FAIL reset_in_wait got stall=%0b wbv=%0b exp 0/0", stall, wb_valid); end
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL reset_in_wait_reads got=%h exp=0", rd_data); end
    // a late mem_valid must not complete the aborted load
    mem_valid = 1; mem_data = 32'hBAD0_BAD0;
    tick();
    mem_valid = 0;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL aborted_load got wbv=%0b exp=0", wb_valid); end
    tick();
    checks++; if (rd_data[31:0] !== 32'h0 && rd_data[63:32] !== 32'h0) begin failures++; $display("FAIL aborted_load_reads got=%h exp=0", rd_data); end
  endtask

  task automatic test_alu_write();
    idle_inputs(); rd_addr = {5'd5, 5'd5};
    wr_req = 1; wr_dst_sel = 1; wr_rd = 5'd5; wr_rt = 5'd9; alu_result = 32'h1234_5678;
    mem_data = 32'hAAAA_AAAA;
    #1;
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL alu_pre got=%h exp=0", rd_data); end
    tick();
    wr_req = 0;
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd5) begin failures++; $display("FAIL alu_stage got wbv=%0b addr=%0d exp 1/5", wb_valid, wb_addr); end
    checks++; if (rd_data !== {2{32'h1234_5678}}) begin failures++; $display("FAIL alu_bypass got=%h exp=%h", rd_data, {2{32'h1234_5678}}); end
    tick();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL alu_drain got wbv=%0b exp=0", wb_valid); end
    checks++; if (rd_data !== {2{32'h1234_5678}}) begin failures++; $display("FAIL alu_array got=%h exp=%h", rd_data, {2{32'h1234_5678}}); end
  endtask

  task automatic test_jal();
    idle_inputs(); rd_addr = {5'd31, 5'd7};
    wr_req = 1; wr_jal = 1; wr_mem = 1; mem_valid = 0; opcplus4 = 32'h0000_0404;
    wr_rd = 5'd7; wr_dst_sel = 1; alu_result = 32'h5555_5555;
    tick();
    idle_inputs();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL jal_stall got=%0b exp=0", stall); end
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd31 || wb_data !== 32'h0000_0404) begin failures++; $display("FAIL jal_stage got %0b/%0d/%h exp 1/31/00000404", wb_valid, wb_addr, wb_data); end
    tick();
    checks++; if (rd_data !== {32'h0000_0404, 32'h0}) begin failures++; $display("FAIL jal_read got=%h exp=%h", rd_data, {32'h0000_0404, 32'h0}); end
  endtask

  task automatic test_load_wait();
    int stall_cnt = 0;
    idle_inputs(); rd_addr = {5'd9, 5'd8};
    wr_req = 1; wr_mem = 1; wr_dst_sel = 0; wr_rt = 5'd8; mem_valid = 0;
    tick();
    if (stall === 1'b1) stall_cnt++;
    // inputs change while stalled; they must be ignored
    wr_rt = 5'd9; alu_result = 32'h7777_7777;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (stall === 1'b1) stall_cnt++;
    end
    checks++; if (stall_cnt != 3) begin failures++; $display("FAIL load_stall_cycles got=%0d exp=3", stall_cnt); end
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL load_no_early_wb got=%0b exp=0", wb_valid); end
    mem_valid = 1; mem_data = 32'hDEAD_BEEF;
    tick();
    idle_inputs();
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL load_release got=%0b exp=0", stall); end
    checks++; if (wb_valid !== 1'b1 || wb_addr !== 5'd8 || wb_data !== 32'hDEAD_BEEF) begin failures++; $display("FAIL load_stage got %0b/%0d/%h exp 1/8/deadbeef", wb_valid, wb_addr, wb_data); end
    tick();
    checks++; if (rd_data !== {32'h0, 32'hDEAD_BEEF}) begin failures++; $display("FAIL load_read got=%h exp=%h", rd_data, {32'h0, 32'hDEAD_BEEF}); end
  endtask

  task automatic test_zero_reg();
    idle_inputs(); rd_addr = {5'd0, 5'd0};
    wr_req = 1; wr_dst_sel = 1; wr_rd = 5'd0; alu_result = 32'hFFFF_FFFF;
    tick();
    idle_inputs();
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL zero_wb_valid got=%0b exp=0", wb_valid); end
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL zero_read_p1 got=%h exp=0", rd_data); end
    tick();
    checks++; if (rd_data !== 64'h0) begin failures++; $display("FAIL zero_read_p2 got=%h exp=0", rd_data); end
  endtask

  task automatic test_back_to_back();
    idle_inputs(); rd_addr = {5'd5, 5'd3};
    wr_req = 1; wr_dst_sel = 1; wr_rd = 5'd3; alu_result = 32'h11;
    tick();
    alu_result = 32'h22;
    checks++; if (rd_data !== {32'h1234_5678, 32'h11}) begin failures++; $display("FAIL b2b_first got=%h exp=%h", rd_data, {32'h1234_5678, 32'h11}); end
    tick();
    idle_inputs();
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h22) begin failures++; $display("FAIL b2b_stage got %0b/%h exp 1/22", wb_valid, wb_data); end
    checks++; if (rd_data[31:0] !== 32'h22) begin failures++; $display("FAIL b2b_second got=%h exp=22", rd_data[31:0]); end
    tick();
    checks++; if (wb_valid !== 1'b0 || rd_data[31:0] !== 32'h22) begin failures++; $display("FAIL b2b_array got wbv=%0b data=%h exp 0/22", wb_valid, rd_data[31:0]); end
  endtask

  initial begin
    reset = 1; rd_addr = '0; idle_inputs();
    test_reset();
    test_alu_write();
    test_jal();
    test_load_wait();
    test_zero_reg();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
